// File: rtl/seven_seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// seven_seg_scan_decoder
// Recovers the hex word shown on a multiplexed 7-segment bus, one per frame.
// Revision: 1.0
// ============================================================================
module seven_seg_scan_decoder #(
    parameter int N_DIGITS   = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg,
    input  logic [N_DIGITS-1:0]     dig_en,
    output logic [4*N_DIGITS-1:0]   value,
    output logic                    frame_valid,
    output logic                    frame_err,
    output logic [N_DIGITS-1:0]     digit_err
);

    localparam int          c_IDX_W  = $clog2(N_DIGITS);
    localparam logic [7:0]  c_STABLE = 8'(STABLE_CYC);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HELD   = 2'd2
    } state_t;

    // Returns {invalid, nibble}; unknown patterns decode to 0 with the flag set.
    function automatic logic [4:0] f_decode(input logic [6:0] s);
        case (s)
            7'h7E:   f_decode = 5'h00;
            7'h30:   f_decode = 5'h01;
            7'h6D:   f_decode = 5'h02;
            7'h79:   f_decode = 5'h03;
            7'h33:   f_decode = 5'h04;
            7'h5B:   f_decode = 5'h05;
            7'h5F:   f_decode = 5'h06;
            7'h70:   f_decode = 5'h07;
            7'h7F:   f_decode = 5'h08;
            7'h7B:   f_decode = 5'h09;
            7'h77:   f_decode = 5'h0A;
            7'h1F:   f_decode = 5'h0B;
            7'h4E:   f_decode = 5'h0C;
            7'h3D:   f_decode = 5'h0D;
            7'h4F:   f_decode = 5'h0E;
            7'h47:   f_decode = 5'h0F;
            default: f_decode = 5'h10;
        endcase
    endfunction

    state_t                  r_state;
    logic [6:0]              r_seg;
    logic [6:0]              r_seg_prev;
    logic [N_DIGITS-1:0]     r_en;
    logic [N_DIGITS-1:0]     r_en_prev;
    logic [7:0]              r_cnt;
    logic [N_DIGITS-1:0]     r_got;
    logic [4*N_DIGITS-1:0]   r_nib;
    logic [N_DIGITS-1:0]     r_err;

    logic                    w_onehot;
    logic                    w_changed;
    logic                    w_capture;
    logic                    w_frame_done;
    logic [N_DIGITS-1:0]     w_cap_mask;
    logic [c_IDX_W-1:0]      w_idx;
    logic [4:0]              w_dec;

    assign w_onehot     = (r_en != '0) && ((r_en & (r_en - N_DIGITS'(1))) == '0);
    assign w_changed    = (r_seg != r_seg_prev) || (r_en != r_en_prev);
    assign w_capture    = (r_state == SETTLE) && !w_changed && (r_cnt == c_STABLE - 8'd1);
    assign w_frame_done = &r_got;
    assign w_cap_mask   = w_capture ? r_en : '0;
    assign w_dec        = f_decode(r_seg);

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (r_en[i]) begin
                w_idx = c_IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg       <= '0;
            r_seg_prev  <= '0;
            r_en        <= '0;
            r_en_prev   <= '0;
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_got       <= '0;
            r_nib       <= '0;
            r_err       <= '0;
            value       <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            digit_err   <= '0;
        end else begin
            r_seg      <= seg;
            r_en       <= dig_en;
            r_seg_prev <= r_seg;
            r_en_prev  <= r_en;

            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_onehot) begin
                        r_state <= SETTLE;
                        r_cnt   <= 8'd1;
                    end
                end
                SETTLE: begin
                    if (w_changed) begin
                        r_state <= w_onehot ? SETTLE : IDLE;
                        r_cnt   <= w_onehot ? 8'd1 : 8'd0;
                    end else begin
                        if (r_cnt != 8'hFF) begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                        if (w_capture) begin
                            r_state                <= HELD;
                            r_nib[4*w_idx +: 4]    <= w_dec[3:0];
                            r_err[w_idx]           <= w_dec[4];
                        end
                    end
                end
                HELD: begin
                    if (w_changed) begin
                        r_state <= w_onehot ? SETTLE : IDLE;
                        r_cnt   <= w_onehot ? 8'd1 : 8'd0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase

            // A capture landing on the completion cycle seeds the next frame.
            frame_valid <= w_frame_done;
            if (w_frame_done) begin
                value     <= r_nib;
                digit_err <= r_err;
                frame_err <= |r_err;
                r_got     <= w_cap_mask;
            end else begin
                r_got     <= r_got | w_cap_mask;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// tb_seven_seg_scan_decoder
// Directed vectors and corner sequences for the 7-segment scan decoder.
// Revision: 1.0
// ============================================================================
module tb_seven_seg_scan_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg_in;
    logic [3:0]  en_in;
    logic [15:0] value;
    logic        frame_valid;
    logic        frame_err;
    logic [3:0]  digit_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pulse_cnt = 0;
    int pulse_cyc = 0;

    typedef struct {
        logic [6:0]  s3;
        logic [6:0]  s2;
        logic [6:0]  s1;
        logic [6:0]  s0;
        logic [15:0] exp_val;
        logic [3:0]  exp_derr;
        logic        exp_ferr;
    } vec_t;

    vec_t vecs [7];

    seven_seg_scan_decoder #(
        .N_DIGITS   (4),
        .STABLE_CYC (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg         (seg_in),
        .dig_en      (en_in),
        .value       (value),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .digit_err   (digit_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (frame_valid) begin
            pulse_cnt = pulse_cnt + 1;
            pulse_cyc = cyc;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic show(input int k, input logic [6:0] s, input int n);
        seg_in = s;
        en_in  = 4'(1 << k);
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        seg_in = 7'h00;
        en_in  = 4'b0000;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int pc;
        int onset;

        vecs[0] = '{7'h30, 7'h6D, 7'h79, 7'h33, 16'h1234, 4'b0000, 1'b0};
        vecs[1] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 16'h0123, 4'b0000, 1'b0};
        vecs[2] = '{7'h33, 7'h5B, 7'h5F, 7'h70, 16'h4567, 4'b0000, 1'b0};
        vecs[3] = '{7'h7F, 7'h7B, 7'h77, 7'h1F, 16'h89AB, 4'b0000, 1'b0};
        vecs[4] = '{7'h4E, 7'h3D, 7'h4F, 7'h47, 16'hCDEF, 4'b0000, 1'b0};
        vecs[5] = '{7'h30, 7'h6D, 7'h00, 7'h33, 16'h1204, 4'b0010, 1'b1};
        vecs[6] = '{7'h08, 7'h7F, 7'h7E, 7'h01, 16'h0800, 4'b1001, 1'b1};

        rst_n  = 1'b0;
        seg_in = 7'h00;
        en_in  = 4'b0000;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(10);
        check("reset_value", 32'(value), 32'h0);
        check("reset_frame_err", 32'(frame_err), 32'h0);
        check("reset_digit_err", 32'(digit_err), 32'h0);
        check("reset_frame_valid", 32'(frame_valid), 32'h0);
        check("reset_no_pulse", 32'(pulse_cnt), 32'h0);

        for (int i = 0; i < 7; i++) begin
            pc = pulse_cnt;
            show(3, vecs[i].s3, 8);
            show(2, vecs[i].s2, 8);
            show(1, vecs[i].s1, 8);
            show(0, vecs[i].s0, 8);
            idle(4);
            check($sformatf("vec%0d_pulses", i), 32'(pulse_cnt - pc), 32'd1);
            check($sformatf("vec%0d_value", i), 32'(value), 32'(vecs[i].exp_val));
            check($sformatf("vec%0d_digit_err", i), 32'(digit_err), 32'(vecs[i].exp_derr));
            check($sformatf("vec%0d_frame_err", i), 32'(frame_err), 32'(vecs[i].exp_ferr));
        end

        // Latency from the last digit's onset to the pulse.
        pc = pulse_cnt;
        show(3, 7'h7E, 8);
        show(2, 7'h30, 8);
        show(1, 7'h6D, 8);
        onset = cyc;
        show(0, 7'h7B, 10);
        idle(2);
        check("lat_pulses", 32'(pulse_cnt - pc), 32'd1);
        check("lat_cycles", 32'(pulse_cyc - onset), 32'd6);
        check("lat_value", 32'(value), 32'h0129);

        // Three-cycle glitch and a multi-hot enable must not capture.
        pc = pulse_cnt;
        show(3, 7'h4E, 8);
        show(2, 7'h3D, 8);
        show(1, 7'h4F, 8);
        show(0, 7'h47, 3);
        seg_in = 7'h7F;
        en_in  = 4'b0011;
        repeat (10) @(negedge clk);
        idle(10);
        check("glitch_no_pulse", 32'(pulse_cnt - pc), 32'd0);
        check("glitch_value_held", 32'(value), 32'h0129);
        show(0, 7'h5B, 4);
        idle(6);
        check("exact_hold_pulses", 32'(pulse_cnt - pc), 32'd1);
        check("exact_hold_value", 32'(value), 32'hCDE5);

        // Recapture of d3 overwrites the earlier nibble.
        pc = pulse_cnt;
        show(3, 7'h30, 8);
        show(2, 7'h6D, 8);
        show(3, 7'h79, 8);
        show(1, 7'h33, 8);
        show(0, 7'h5B, 8);
        idle(4);
        check("recap_pulses", 32'(pulse_cnt - pc), 32'd1);
        check("recap_value", 32'(value), 32'h3245);

        // Reset mid-frame drops the partial frame.
        pc = pulse_cnt;
        show(3, 7'h7E, 8);
        show(2, 7'h7E, 8);
        show(1, 7'h7E, 8);
        idle(2);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_value", 32'(value), 32'h0);
        check("midrst_frame_valid", 32'(frame_valid), 32'h0);
        rst_n = 1'b1;
        idle(2);
        show(0, 7'h5F, 8);
        show(1, 7'h70, 8);
        show(2, 7'h7F, 8);
        show(3, 7'h77, 8);
        idle(4);
        check("midrst_pulses", 32'(pulse_cnt - pc), 32'd1);
        check("midrst_new_value", 32'(value), 32'hA876);
        check("midrst_digit_err", 32'(digit_err), 32'h0);
        check("midrst_frame_err", 32'(frame_err), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
